muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the EX stage of the MIPS pipeline. It owns the architectural HI/LO registers, runs signed and unsigned MULT/DIV operations over several cycles, and drives the `stall`/`done` pair consumed by the hazard unit. It aborts cleanly when the pipeline is flushed by an exception.

## Interface
Parameters:
- MUL_LAT, 2: multiplier pipeline depth in cycles (1..4).

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous, active-low reset.
- op_valid  in  1  EX holds a mul/div instruction; held high while EX is stalled.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- src_a  in  32  rs operand (dividend / multiplicand).
- src_b  in  32  rt operand (divisor / multiplier).
- cancel  in  1  exception flush; aborts the operation in flight.
- hi_we  in  1  MTHI write.
- lo_we  in  1  MTLO write.
- hilo_wdata  in  32  MTHI/MTLO data.
- stall  out  1  to hazard unit: operation not yet complete.
- done  out  1  one-cycle completion pulse, concurrent with stall.
- busy  out  1  FSM not in IDLE.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Start rule:
  - A start is accepted in IDLE when op_valid && !held && !cancel && op is legal.
  - `held` is set on leaving DONE and cleared in any cycle with op_valid=0 or cancel=1. This prevents re-issue of the same stalled instruction.
- Transitions:
  - IDLE→MUL on a multiply-class start.
  - IDLE→DIV on a divide start.
  - MUL→DONE after MUL_LAT cycles.
  - DIV→FIX after 32 iterations; FIX→DONE; DONE→IDLE.
- Operand latching: operands are latched at start; src_a/src_b are don't-care afterwards.
- Divide:
  - Radix-2 restoring divide on absolute values, one quotient bit per cycle. A 6-bit counter counts 0..31.
  - FIX applies signs: quotient negative iff signs differ (signed); remainder takes the dividend's sign.
- Divide by zero: LO=0xFFFF_FFFF, HI=src_a, for both signed and unsigned.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0.
- Multiply: 64-bit product, signed or unsigned, {HI,LO}=product.
- Commit:
  - The result is written to HI/LO on the clock edge ending DONE, unless cancel is high in that cycle.
  - MADD/MSUB: {HI,LO} ± product, mod 2^64.
- stall = (start accepted this cycle) || (state != IDLE).
- done = (state == DONE) && !cancel.
- cancel: any state → IDLE on the next edge. HI/LO are unchanged; no done pulse.
- MTHI/MTLO:
  - Honoured only in IDLE with no start this cycle; ignored otherwise.
  - hi_we and lo_we together write both registers.

## Timing
- Reset (resetn=0, async): state=IDLE, held=0, HI=LO=0, stall=done=busy=0.
- Cycle 0 = start cycle (IDLE, stall=1, combinational).
- Multiply:
  - MUL occupies cycles 1..MUL_LAT; DONE in cycle MUL_LAT+1.
  - HI/LO show the new value in cycle MUL_LAT+2.
- Divide:
  - DIV occupies cycles 1..32, FIX cycle 33, DONE cycle 34.
  - HI/LO show the new value in cycle 35.
- busy is registered (state != IDLE). stall and done are combinational from state, op_valid and cancel.
- Back-to-back: the next start is possible in the first IDLE cycle where op_valid has dropped, or risen again after a low cycle.
- Reset mid-operation: immediate return to the reset values.

## Configuration
- MULDIV_MADD_EN defined: op 100–111 perform accumulate/subtract into {HI,LO} as above.
- Undefined: op 100–111 are illegal. There is no start, no stall, and HI/LO are untouched. The accumulate adder is not built.

## Structure
- Package muldiv_pkg holds:
  - op encoding localparams (OP_MULT..OP_MSUBU);
  - the state enum;
  - divide iteration count DIV_ITER=32.
- Sub-module div_iter: unsigned 32/32 restoring divider core. Interface: start, 32-bit operands, quotient/remainder, 32-iteration counter, ready. The sign fix and the FSM stay in muldiv_ctrl.

## Test plan
- MULT 0xFFFF_FFFE × 0x0000_0003, MUL_LAT=2 → stall cycles 0–3, done in cycle 3, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. MULTU on the same operands → HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIV −7 / 2 → done in cycle 34, LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 100 / 7 → LO=14, HI=2.
- DIV 5 / 0 → LO=0xFFFF_FFFF, HI=5. DIV 0x8000_0000 / −1 → LO=0x8000_0000, HI=0.
- Cancel:
  - cancel in cycle 10 of DIV → IDLE next cycle, no done, HI/LO unchanged.
  - cancel in the DONE cycle → done=0, no commit.
- op_valid held high for 3 cycles after done → no second start. Drop op_valid for 1 cycle, then MTLO 0x1234 → LO=0x1234.
- With MULDIV_MADD_EN, HI=0, LO=0xFFFF_FFFF, MADDU 1×1 → HI=1, LO=0. Without the macro the same op → stall never asserted, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM state type, divide iteration count and an operand magnitude helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  localparam int DIV_ITER = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  // Magnitude of a 32-bit operand; only negates when the op is signed.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned 32/32 radix-2 restoring divider core, one quotient bit per cycle.
// Latency: start cycle loads operands, then 32 iteration cycles (count 0..31).
// No backpressure: a start always reloads, even while an earlier divide runs.
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [5:0]  count,
  output logic        ready
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [32:0] shifted;
  logic        fits;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    shifted = {rem_q, quo_q[31]};
    fits    = (shifted >= {1'b0, dvs_q});
    if (start) begin
      rem_d = 32'd0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = 6'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = fits ? (shifted[31:0] - dvs_q) : shifted[31:0];
      quo_d = {quo_q[30:0], fits};
      if (cnt_q == 6'(DIV_ITER - 1)) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q <= 32'd0;
      quo_q <= 32'd0;
      dvs_q <= 32'd0;
      cnt_q <= 6'd0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign count     = cnt_q;
  assign ready     = !run_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage MULT/DIV sequencer owning HI/LO; MULDIV_MADD_EN enables MADD/MSUB ops.
// Latency: multiply MUL_LAT+2 cycles to visible HI/LO, divide 35 cycles.
// Backpressure: stall held from start cycle through DONE; cancel aborts to IDLE.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_wdata,
  output logic        stall,
  output logic        done,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state_q, state_d;
  logic        held_q, held_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [2:0]  mcnt_q, mcnt_d;
  logic [63:0] res_q, res_d;
`ifdef MULDIV_MADD_EN
  logic        acc_q, acc_d, sub_q, sub_d;
`endif

  logic        op_legal, op_is_div, start;
  logic [63:0] a_ext, b_ext, product, commit_val;
  logic [31:0] div_quo, div_rem, q_fix, r_fix;
  logic [5:0]  div_cnt;
  logic        div_ready;

`ifdef MULDIV_MADD_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = !op[2];
`endif
  assign op_is_div = (op[2:1] == 2'b01);
  // Gated by resetn so stall stays low while reset is asserted.
  assign start = resetn && (state_q == S_IDLE) && op_valid && !held_q && !cancel && op_legal;

  div_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start && op_is_div),
    .dividend  (abs32(src_a, !op[0])),
    .divisor   (abs32(src_b, !op[0])),
    .quotient  (div_quo),
    .remainder (div_rem),
    .count     (div_cnt),
    .ready     (div_ready)
  );

  // Product, divide sign fix-up and the value written to HI/LO at commit.
  always_comb begin
    a_ext   = {{32{sgn_q & a_q[31]}}, a_q};
    b_ext   = {{32{sgn_q & b_q[31]}}, b_q};
    product = a_ext * b_ext;
    q_fix   = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - div_quo) : div_quo;
    r_fix   = (sgn_q && a_q[31]) ? (32'd0 - div_rem) : div_rem;
`ifdef MULDIV_MADD_EN
    if (acc_q) begin
      commit_val = sub_q ? ({hi_q, lo_q} - res_q) : ({hi_q, lo_q} + res_q);
    end else begin
      commit_val = res_q;
    end
`else
    commit_val = res_q;
`endif
  end

  // Next-state logic for the FSM, operand latches and HI/LO.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    mcnt_d  = mcnt_q;
    res_d   = res_q;
`ifdef MULDIV_MADD_EN
    acc_d   = acc_q;
    sub_d   = sub_q;
`endif
    // Blocks re-issue of the instruction still sitting in a stalled EX.
    held_d = held_q;
    if (!op_valid || cancel) begin
      held_d = 1'b0;
    end else if (state_q == S_DONE) begin
      held_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = src_a;
          b_d     = src_b;
          sgn_d   = !op[0];
          mcnt_d  = 3'd0;
`ifdef MULDIV_MADD_EN
          acc_d   = op[2];
          sub_d   = op[2] & op[1];
`endif
          state_d = op_is_div ? S_DIV : S_MUL;
        end else begin
          if (hi_we) hi_d = hilo_wdata;
          if (lo_we) lo_d = hilo_wdata;
        end
      end
      S_MUL: begin
        if (mcnt_q == 3'(MUL_LAT - 1)) begin
          res_d   = product;
          state_d = S_DONE;
        end else begin
          mcnt_d = mcnt_q + 3'd1;
        end
      end
      S_DIV: begin
        if (!div_ready && (div_cnt == 6'(DIV_ITER - 1))) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        res_d   = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {r_fix, q_fix};
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!cancel) begin
          {hi_d, lo_d} = commit_val;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (cancel) begin
      state_d = S_IDLE;
    end
    busy_d = (state_d != S_IDLE);
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      held_q  <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      mcnt_q  <= 3'd0;
      res_q   <= 64'd0;
`ifdef MULDIV_MADD_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      mcnt_q  <= mcnt_d;
      res_q   <= res_d;
`ifdef MULDIV_MADD_EN
      acc_q   <= acc_d;
      sub_q   <= sub_d;
`endif
    end
  end

  assign stall = start || (state_q != S_IDLE);
  assign done  = (state_q == S_DONE) && !cancel;
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table of MULT/DIV results plus
// hand-written cancel, re-issue, MTHI/MTLO, accumulate and reset sequences.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int LAT = 2;
  localparam int MUL_DONE = LAT + 1;
  localparam int DIV_DONE = 34;
  localparam int NVEC = 10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        cancel = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] hilo_wdata = 32'd0;
  logic        stall, done, busy;
  logic [31:0] hi, lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_done;
  } vec_t;

  vec_t vecs[NVEC];
  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.MUL_LAT(LAT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .op_valid   (op_valid),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .cancel     (cancel),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hilo_wdata (hilo_wdata),
    .stall      (stall),
    .done       (done),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op, scramble operands after the start cycle, wait for done.
  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    logic stall_ok;
    logic seen;
    @(negedge clk);
    op_valid = 1'b1; op = v.op; src_a = v.a; src_b = v.b;
    #1;
    chk($sformatf("v%0d start_stall", idx), 64'(stall), 64'd1);
    cyc = 0; stall_ok = 1'b1; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      src_a = $urandom; src_b = $urandom; op = 3'($urandom);
      #1;
      if (!stall) stall_ok = 1'b0;
      if (done) seen = 1'b1;
    end
    chk($sformatf("v%0d done_cycle", idx), 64'(cyc), 64'(v.exp_done));
    chk($sformatf("v%0d stall_through_done", idx), 64'(stall_ok), 64'd1);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    chk($sformatf("v%0d hi", idx), 64'(hi), 64'(v.exp_hi));
    chk($sformatf("v%0d lo", idx), 64'(lo), 64'(v.exp_lo));
    chk($sformatf("v%0d idle_busy", idx), 64'(busy), 64'd0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] keep_hi, keep_lo;
    logic        bad;
    vec_t        mv;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_DONE};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, MUL_DONE};
    vecs[2] = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, MUL_DONE};
    vecs[3] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_DONE};
    vecs[4] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_DONE};
    vecs[5] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_DONE};
    vecs[6] = '{OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV_DONE};
    vecs[7] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_DONE};
    vecs[8] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_DONE};
    vecs[9] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, DIV_DONE};

    // Reset state, with op_valid already high.
    op_valid = 1'b1;
    step(2);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    op_valid = 1'b0;
    resetn = 1'b1;
    step(1);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Cancel in cycle 10 of a divide: no done, HI/LO unchanged.
    keep_hi = vecs[NVEC-1].exp_hi;
    keep_lo = vecs[NVEC-1].exp_lo;
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    bad = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk); #1;
      if (done || !stall) bad = 1'b1;
    end
    @(negedge clk);
    cancel = 1'b1;
    #1;
    chk("cancel_div_running", 64'(bad), 64'd0);
    chk("cancel_div_done", 64'(done), 64'd0);
    @(negedge clk);
    cancel = 1'b0; op_valid = 1'b0;
    #1;
    chk("cancel_div_busy", 64'(busy), 64'd0);
    chk("cancel_div_stall", 64'(stall), 64'd0);
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done || busy) bad = 1'b1;
    end
    chk("cancel_div_quiet", 64'(bad), 64'd0);
    chk("cancel_div_hilo", {32'(hi), 32'(lo)}, {keep_hi, keep_lo});

    // Cancel in the DONE cycle of a multiply: no pulse, no commit.
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd5;
    step(LAT);
    @(negedge clk);
    cancel = 1'b1;
    #1;
    chk("cancel_done_done", 64'(done), 64'd0);
    chk("cancel_done_stall", 64'(stall), 64'd1);
    @(negedge clk);
    cancel = 1'b0; op_valid = 1'b0;
    #1;
    chk("cancel_done_busy", 64'(busy), 64'd0);
    chk("cancel_done_hilo", {32'(hi), 32'(lo)}, {keep_hi, keep_lo});

    // Held op_valid after done must not re-issue; MTHI during MUL ignored.
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd3;
    @(negedge clk);
    hi_we = 1'b1; hilo_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    @(negedge clk); #1;
    chk("held_done_pulse", 64'(done), 64'd1);
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (stall || busy || done) bad = 1'b1;
    end
    chk("held_no_reissue", 64'(bad), 64'd0);
    chk("held_hi_mthi_ignored", 64'(hi), 64'd0);
    chk("held_lo", 64'(lo), 64'd6);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    lo_we = 1'b1; hilo_wdata = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    #1;
    chk("mtlo_lo", 64'(lo), 64'h1234);
    chk("mtlo_hi_kept", 64'(hi), 64'd0);

    // Both write enables together, then HI=0, LO=all ones.
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; hilo_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    lo_we = 1'b0; hilo_wdata = 32'd0;
    #1;
    chk("mthilo_both_lo", 64'(lo), 64'hFFFF_FFFF);
    @(negedge clk);
    hi_we = 1'b0;
    #1;
    chk("mthi_hi", 64'(hi), 64'd0);

`ifdef MULDIV_MADD_EN
    mv = '{OP_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, MUL_DONE};
    run_vec(mv, 100);
    mv = '{OP_MSUB, 32'd2, 32'd3, 32'd0, 32'hFFFF_FFFA, MUL_DONE};
    run_vec(mv, 101);
`else
    mv = '{OP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0};
    @(negedge clk);
    op_valid = 1'b1; op = mv.op; src_a = mv.a; src_b = mv.b;
    #1;
    chk("madd_off_stall", 64'(stall), 64'd0);
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (stall || busy || done) bad = 1'b1;
    end
    chk("madd_off_quiet", 64'(bad), 64'd0);
    chk("madd_off_hilo", {32'(hi), 32'(lo)}, {mv.exp_hi, mv.exp_lo});
    @(negedge clk);
    op_valid = 1'b0;
`endif

    // Reset in the middle of a divide.
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIV; src_a = 32'd50; src_b = 32'd3;
    step(5);
    chk("midrst_busy_before", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_hilo", {32'(hi), 32'(lo)}, 64'd0);
    @(negedge clk);
    op_valid = 1'b0; resetn = 1'b1;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
